// File: rtl/ctrl_exposure_time.sv
// Exposure-time setting controller.
// Turns the increase/decrease push-button levels into a saturating exposure
// time (ms) for the control FSM. Each button is synchronised, edge-detected
// and auto-repeated while held.
//
// Ports:
//   Clk          - single clock, rising edge
//   Reset        - asynchronous active-low reset
//   Exp_increase - increase button level (asynchronous to Clk)
//   Exp_decrease - decrease button level (asynchronous to Clk)
//   EX_time      - current exposure time, registered, unsigned 5 bits
module ctrl_exposure_time #(
  parameter int unsigned EXP_MIN       = 2,
  parameter int unsigned EXP_MAX       = 30,
  parameter int unsigned EXP_DEFAULT   = 15,
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_PERIOD = 100
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Exp_increase,
  input  logic       Exp_decrease,
  output logic [4:0] EX_time
);

  localparam int unsigned EXP_W = 5;
  localparam int unsigned CNT_W = (REPEAT_DELAY  >= 65536) ? $clog2(REPEAT_DELAY + 1) : 16;
  localparam int unsigned PER_W = (REPEAT_PERIOD >= 65536) ? $clog2(REPEAT_PERIOD)    : 16;

  localparam logic [EXP_W-1:0] MIN_V     = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0] MAX_V     = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] DEF_V     = EXP_W'(EXP_DEFAULT);
  localparam logic [CNT_W-1:0] DELAY_V   = CNT_W'(REPEAT_DELAY);
  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(REPEAT_PERIOD - 1);
  localparam bit               REPEAT_EN = (REPEAT_DELAY != 0);

  // Bit 0 = increase, bit 1 = decrease.
  logic [1:0] btn;
  logic [1:0] req;

  assign btn = {Exp_decrease, Exp_increase};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic             s1;
    logic             s2;
    logic             prev;
    logic [CNT_W-1:0] hold_cnt;
    logic [PER_W-1:0] per_cnt;
    logic             at_delay;
    logic             tick;

    // hold_cnt counts held cycles since the edge and parks at REPEAT_DELAY;
    // per_cnt then paces the repeats. Both clear as soon as s2 drops.
    assign at_delay = (hold_cnt == DELAY_V);
    assign tick     = REPEAT_EN && s2 && at_delay && (per_cnt == '0);
    assign req[b]   = (s2 & ~prev) | tick;

    // Synchroniser, edge-detect history and hold counters.
    always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
        s1       <= 1'b0;
        s2       <= 1'b0;
        prev     <= 1'b0;
        hold_cnt <= '0;
        per_cnt  <= '0;
      end else begin
        s1   <= btn[b];
        s2   <= s1;
        prev <= s2;
        if (!s2) begin
          hold_cnt <= '0;
          per_cnt  <= '0;
        end else if (!at_delay) begin
          hold_cnt <= hold_cnt + CNT_W'(1);
        end else begin
          per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + PER_W'(1);
        end
      end
    end
  end

  // Saturating update; limits are checked before stepping so nothing wraps.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      EX_time <= DEF_V;
    end else begin
      if (req[0] && !req[1] && (EX_time < MAX_V)) begin
        EX_time <= EX_time + EXP_W'(1);
      end else if (req[1] && !req[0] && (EX_time > MIN_V)) begin
        EX_time <= EX_time - EXP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ctrl_exposure_time.sv
// Self-checking bench for ctrl_exposure_time (REPEAT_DELAY=10, REPEAT_PERIOD=4).
module tb_ctrl_exposure_time;

  localparam int D   = 10;
  localparam int P   = 4;
  localparam int MIN = 2;
  localparam int MAX = 30;
  localparam int DEF = 15;

  logic       Clk;
  logic       Reset;
  logic       Exp_increase;
  logic       Exp_decrease;
  logic [4:0] EX_time;

  int checks;
  int errors;

  // Reference model state: run lengths of high samples, last sample, value.
  int m_ex;
  int run_i;
  int run_d;
  bit sp_i;
  bit sp_d;
  bit m_ui;
  bit m_ud;

  ctrl_exposure_time #(
    .EXP_MIN(MIN), .EXP_MAX(MAX), .EXP_DEFAULT(DEF),
    .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Exp_increase(Exp_increase),
    .Exp_decrease(Exp_decrease),
    .EX_time(EX_time)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // A held button of run length n (samples seen two edges back) steps when
  // n==1 (fresh press) or when n-1 = D + k*P.
  function automatic bit step_due(input int run);
    if (run == 0) return 1'b0;
    if (run == 1) return 1'b1;
    if (D == 0 || (run - 1) < D) return 1'b0;
    return ((run - 1 - D) % P) == 0;
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_ex  = DEF;
      run_i = 0;
      run_d = 0;
      sp_i  = 1'b0;
      sp_d  = 1'b0;
    end else begin
      m_ui = step_due(run_i);
      m_ud = step_due(run_d);
      if (m_ui && !m_ud && m_ex < MAX) m_ex = m_ex + 1;
      else if (m_ud && !m_ui && m_ex > MIN) m_ex = m_ex - 1;
      run_i = sp_i ? ((run_i < 1000000) ? run_i + 1 : run_i) : 0;
      run_d = sp_d ? ((run_d < 1000000) ? run_d + 1 : run_d) : 0;
      sp_i  = Exp_increase;
      sp_d  = Exp_decrease;
    end
  end

  task automatic reset_pulse();
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Exp_increase = 1'b0;
    Exp_decrease = 1'b0;
    #1 Reset = 1'b0;
    #2;
    checks++;
    if (EX_time !== 5'(DEF)) begin
      errors++;
      $display("FAIL reset_async: got %0d expected %0d", EX_time, DEF);
    end
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (EX_time !== 5'(DEF)) begin
      errors++;
      $display("FAIL reset_held: got %0d expected %0d", EX_time, DEF);
    end
    Reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      checks++;
      if (EX_time !== 5'(DEF)) begin
        errors++;
        $display("FAIL reset_idle c=%0d: got %0d expected %0d", c, EX_time, DEF);
      end
    end
  endtask

  task automatic test_pulses();
    int e;
    for (int c = 0; c < 12; c++) begin
      Exp_increase = (c < 8) && (c % 2 == 0);
      @(negedge Clk);
      e = 15 + ((c >= 2) ? (((c - 2) / 2 + 1 > 4) ? 4 : (c - 2) / 2 + 1) : 0);
      checks++;
      if (EX_time !== 5'(e)) begin
        errors++;
        $display("FAIL inc_pulse c=%0d: got %0d expected %0d", c, EX_time, e);
      end
    end
    for (int c = 0; c < 10; c++) begin
      Exp_decrease = (c < 6) && (c % 2 == 0);
      @(negedge Clk);
      e = 19 - ((c >= 2) ? (((c - 2) / 2 + 1 > 3) ? 3 : (c - 2) / 2 + 1) : 0);
      checks++;
      if (EX_time !== 5'(e)) begin
        errors++;
        $display("FAIL dec_pulse c=%0d: got %0d expected %0d", c, EX_time, e);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 40; i++) begin
      Exp_increase = (i % 2 == 0);
      @(negedge Clk);
      checks++;
      if (EX_time !== 5'(m_ex) || EX_time > 5'(MAX)) begin
        errors++;
        $display("FAIL sat_up i=%0d: got %0d expected %0d", i, EX_time, m_ex);
      end
    end
    Exp_increase = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (EX_time !== 5'(MAX)) begin
      errors++;
      $display("FAIL sat_top: got %0d expected %0d", EX_time, MAX);
    end
    for (int i = 0; i < 80; i++) begin
      Exp_decrease = (i % 2 == 0);
      @(negedge Clk);
      checks++;
      if (EX_time !== 5'(m_ex) || EX_time < 5'(MIN)) begin
        errors++;
        $display("FAIL sat_down i=%0d: got %0d expected %0d", i, EX_time, m_ex);
      end
    end
    Exp_decrease = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (EX_time !== 5'(MIN)) begin
      errors++;
      $display("FAIL sat_bottom: got %0d expected %0d", EX_time, MIN);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 10; i++) begin
      Exp_increase = (i % 2 == 0);
      @(negedge Clk);
    end
    Exp_increase = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (EX_time !== 5'd7) begin
      errors++;
      $display("FAIL simul_setup: got %0d expected %0d", EX_time, 7);
    end
    // One-cycle simultaneous press, then a long simultaneous hold.
    Exp_increase = 1'b1;
    Exp_decrease = 1'b1;
    @(negedge Clk);
    Exp_increase = 1'b0;
    Exp_decrease = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      checks++;
      if (EX_time !== 5'd7) begin
        errors++;
        $display("FAIL simul_pulse c=%0d: got %0d expected %0d", c, EX_time, 7);
      end
    end
    Exp_increase = 1'b1;
    Exp_decrease = 1'b1;
    for (int c = 0; c < 34; c++) begin
      if (c == 30) begin
        Exp_increase = 1'b0;
        Exp_decrease = 1'b0;
      end
      @(negedge Clk);
      checks++;
      if (EX_time !== 5'd7) begin
        errors++;
        $display("FAIL simul_hold c=%0d: got %0d expected %0d", c, EX_time, 7);
      end
    end
  endtask

  task automatic test_auto_repeat();
    int sched [6];
    int e;
    sched = '{2, 12, 16, 20, 24, 28};
    reset_pulse();
    for (int c = 0; c < 40; c++) begin
      Exp_increase = (c < 30);
      @(negedge Clk);
      e = 15;
      for (int k = 0; k < 6; k++) if (sched[k] <= c) e++;
      checks++;
      if (EX_time !== 5'(e) || EX_time !== 5'(m_ex)) begin
        errors++;
        $display("FAIL auto_repeat c=%0d: got %0d expected %0d model %0d", c, EX_time, e, m_ex);
      end
    end
    checks++;
    if (EX_time !== 5'd21) begin
      errors++;
      $display("FAIL auto_repeat_final: got %0d expected %0d", EX_time, 21);
    end
  endtask

  task automatic test_reset_mid_hold();
    int sched [4];
    int e;
    sched = '{2, 12, 16, 20};
    reset_pulse();
    Exp_increase = 1'b1;
    repeat (25) @(negedge Clk);
    checks++;
    if (EX_time !== 5'd20) begin
      errors++;
      $display("FAIL midhold_setup: got %0d expected %0d", EX_time, 20);
    end
    #1 Reset = 1'b0;
    #1;
    checks++;
    if (EX_time !== 5'(DEF)) begin
      errors++;
      $display("FAIL midhold_async: got %0d expected %0d", EX_time, DEF);
    end
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge Clk);
      e = 15;
      for (int k = 0; k < 4; k++) if (sched[k] <= c) e++;
      checks++;
      if (EX_time !== 5'(e) || EX_time !== 5'(m_ex)) begin
        errors++;
        $display("FAIL midhold_release c=%0d: got %0d expected %0d model %0d", c, EX_time, e, m_ex);
      end
    end
    Exp_increase = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_random();
    int left_i;
    int left_d;
    left_i = 0;
    left_d = 0;
    reset_pulse();
    for (int c = 0; c < 600; c++) begin
      if (left_i == 0) begin
        Exp_increase = 1'($urandom_range(0, 1));
        left_i = $urandom_range(1, 25);
      end
      if (left_d == 0) begin
        Exp_decrease = 1'($urandom_range(0, 1));
        left_d = $urandom_range(1, 25);
      end
      left_i--;
      left_d--;
      @(negedge Clk);
      checks++;
      if (EX_time !== 5'(m_ex) || EX_time < 5'(MIN) || EX_time > 5'(MAX)) begin
        errors++;
        $display("FAIL random c=%0d: got %0d expected %0d", c, EX_time, m_ex);
      end
    end
    Exp_increase = 1'b0;
    Exp_decrease = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_pulses();
    test_saturation();
    test_simultaneous();
    test_auto_repeat();
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
